fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the 16-bit word-addressed main memory. Drives the memory read address from a program counter and captures the returned word into a small prefetch FIFO. Presents instructions with their PCs to decode over a valid/ready handshake. Supports a branch redirect that flushes the FIFO, and a grant input so a load/store path can steal the memory port.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_unit.sv | 77 +++++++
 tb/tb_fetch_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and the fetch entry type for the instruction fetch stage.
package fetch_pkg;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 16;
  localparam int FIFO_DEPTH = 4;

  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH entries, push/pop/flush, occupancy count, head entry
// presented straight from the storage registers.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  output fetch_entry_t       head_data,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t       mem_q   [DEPTH];
  fetch_entry_t       mem_d   [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Next-state for storage, pointers and count; flush beats push and pop.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_data;
        tail_d        = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset also clears the storage so the head output is never X.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; combinational logic above uses blocking.
    if (reset) begin
      // NOTE: storage is reset deliberately -- the head word is a visible output right after reset.
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_data = mem_q[head_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the memory read address from the PC,
// captures returned words into the prefetch FIFO and hands them to decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int  DEPTH = FIFO_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_grant,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic [CNT_W-1:0]  occupancy
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              push;
  logic              pop;
  logic              fifo_full;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign fifo_full   = (occupancy == FULL_COUNT);
  assign instr_valid = (occupancy != '0);

  // Push/pop decisions and next fetch address; redirect overrides both.
  always_comb begin
    push       = mem_grant && !fifo_full && !redirect;
    pop        = instr_valid && instr_ready && !redirect;
    push_entry = '{instr: mem_data, pc: fetch_pc_q};
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + 1'b1;
    end
  end

  // Program counter register; wraps naturally at the top of the address space.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (occupancy)
  );

  assign mem_addr  = fetch_pc_q;
  assign mem_write = 1'b0;
  assign instr     = head_entry.instr;
  assign instr_pc  = head_entry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit: a queue-based reference model
// predicts the instruction stream; a negedge monitor compares the DUT to it.
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        mem_grant;
  logic [15:0] mem_addr;
  logic        mem_write;
  logic [15:0] mem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic [2:0]  occupancy;

  logic [15:0] mem [0:65535];

  exp_t        exp_q[$];
  logic [15:0] model_pc;
  bit          armed;
  int          checks;
  int          errors;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .mem_grant   (mem_grant),
    .mem_addr    (mem_addr),
    .mem_write   (mem_write),
    .mem_data    (mem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .occupancy   (occupancy)
  );

  assign mem_data = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then after the clock edge advance the model:
  // reset beats redirect; otherwise a granted fetch into a non-full FIFO
  // appends the word at the current PC and moves the PC on by one.
  task automatic step(input logic r, input logic rd, input logic [15:0] rpc,
                      input logic g, input logic rdy);
    int occ;
    reset       = r;
    redirect    = rd;
    redirect_pc = rpc;
    mem_grant   = g;
    instr_ready = rdy;
    occ         = exp_q.size();
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      model_pc = RESET_PC;
      armed    = 1'b1;
    end else if (rd) begin
      exp_q.delete();
      model_pc = rpc;
    end else if (g && occ < DEPTH) begin
      exp_q.push_back('{instr: mem[model_pc], pc: model_pc});
      model_pc = model_pc + 16'd1;
    end
  endtask

  // Monitor: compare what the DUT presents against the head of the model queue
  // every cycle, and retire the head when decode accepts it.
  always @(negedge clk) begin
    if (armed) begin
      check("instr_valid", {31'd0, instr_valid}, {31'd0, exp_q.size() != 0});
      check("occupancy", {29'd0, occupancy}, exp_q.size());
      check("mem_addr", {16'd0, mem_addr}, {16'd0, model_pc});
      check("mem_write", {31'd0, mem_write}, 32'd0);
      if (exp_q.size() != 0 && instr_valid) begin
        check("instr", {16'd0, instr}, {16'd0, exp_q[0].instr});
        check("instr_pc", {16'd0, instr_pc}, {16'd0, exp_q[0].pc});
      end
      if (exp_q.size() != 0 && instr_ready && !redirect && !reset) begin
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    bit gpat [5];
    checks   = 0;
    errors   = 0;
    armed    = 1'b0;
    model_pc = RESET_PC;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    mem[2] = 16'h3333;
    mem[3] = 16'h4444;

    // Reset: outputs cleared.
    step(1, 0, 16'h0, 1, 1);
    step(1, 0, 16'h0, 1, 1);
    check("reset_instr", {16'd0, instr}, 32'd0);
    check("reset_instr_pc", {16'd0, instr_pc}, 32'd0);
    check("reset_occupancy", {29'd0, occupancy}, 32'd0);
    check("reset_mem_addr", {16'd0, mem_addr}, {16'd0, RESET_PC});

    // Streaming with grant and ready: first word visible one cycle later.
    step(0, 0, 16'h0, 1, 1);
    check("first_instr", {16'd0, instr}, 32'h1111);
    repeat (7) step(0, 0, 16'h0, 1, 1);

    // Back-pressure: FIFO saturates, then drains without gaps.
    repeat (10) step(0, 0, 16'h0, 1, 0);
    check("saturate_occupancy", {29'd0, occupancy}, DEPTH);
    repeat (8) step(0, 0, 16'h0, 1, 1);

    // Grant gaps.
    gpat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) step(0, 0, 16'h0, gpat[i], 1);
    repeat (3) step(0, 0, 16'h0, 1, 1);

    // Redirect with three entries queued.
    step(0, 1, 16'h0200, 1, 1);
    repeat (3) step(0, 0, 16'h0, 1, 0);
    check("three_queued", {29'd0, occupancy}, 32'd3);
    step(0, 1, 16'h0100, 1, 1);
    check("redirect_valid", {31'd0, instr_valid}, 32'd0);
    check("redirect_occupancy", {29'd0, occupancy}, 32'd0);
    check("redirect_mem_addr", {16'd0, mem_addr}, 32'h0100);
    step(0, 0, 16'h0, 1, 1);
    check("redirect_target_valid", {31'd0, instr_valid}, 32'd1);
    check("redirect_target_pc", {16'd0, instr_pc}, 32'h0100);
    repeat (3) step(0, 0, 16'h0, 1, 1);

    // Address wrap at the top of memory.
    step(0, 1, 16'hFFFE, 1, 1);
    step(0, 0, 16'h0, 1, 1);
    check("wrap_first_pc", {16'd0, instr_pc}, 32'hFFFE);
    step(0, 0, 16'h0, 1, 1);
    check("wrap_second_pc", {16'd0, instr_pc}, 32'hFFFF);
    step(0, 0, 16'h0, 1, 1);
    check("wrap_third_pc", {16'd0, instr_pc}, 32'h0000);
    repeat (3) step(0, 0, 16'h0, 1, 1);

    // Full FIFO with reset and redirect together: reset wins.
    repeat (6) step(0, 0, 16'h0, 1, 0);
    check("prefill_full", {29'd0, occupancy}, DEPTH);
    step(1, 1, 16'h0100, 1, 1);
    check("reset_wins_valid", {31'd0, instr_valid}, 32'd0);
    check("reset_wins_occupancy", {29'd0, occupancy}, 32'd0);
    check("reset_wins_mem_addr", {16'd0, mem_addr}, {16'd0, RESET_PC});

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 64) == 0, ($urandom % 16) == 0, 16'($urandom),
           ($urandom % 4) != 0, ($urandom % 4) != 0);
    end
    repeat (6) step(0, 0, 16'h0, 1, 1);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
